// File: rtl/gf_arb_pkg.sv
// Shared types and constants for the gf_add_arbiter slice: operand bundle,
// add-mode encoding and output-slot state.
package gf_arb_pkg;

    localparam int   GF_W     = 32;
    localparam int   NREQ_MAX = 8;
    localparam logic MODE_INT = 1'b0;
    localparam logic MODE_GF  = 1'b1;

    typedef struct packed {
        logic [GF_W-1:0] a;
        logic [GF_W-1:0] b;
        logic            gf;
    } gf_arb_req_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } gf_arb_state_t;

endpackage

// File: rtl/gf_rca_adder.sv
// Shared W-bit adder: ripple-carry integer add (carry-out dropped) or GF(2)
// carry-less add, selected by gf.
module gf_rca_adder #(
    parameter int W = 32
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         gf,
    output logic [W-1:0] sum
);

    logic [W-1:0] carry_s;

    // Carry chain; the final carry-out is never formed since results wrap.
    always_comb begin
        carry_s      = '0;
        carry_s[0]   = 1'b0;
        for (int i = 0; i < W - 1; i++) begin
            carry_s[i+1] = (a[i] & b[i]) | (carry_s[i] & (a[i] ^ b[i]));
        end
    end

    // GF mode masks every carry, leaving a plain XOR.
    always_comb begin
        sum = '0;
        for (int i = 0; i < W; i++) begin
            sum[i] = a[i] ^ b[i] ^ (carry_s[i] & ~gf);
        end
    end

endmodule

// File: rtl/rr_grant.sv
// Combinational round-robin picker: searches last+1, last+2, ... (mod NREQ)
// and returns the first requesting index as one-hot and encoded forms.
module rr_grant #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            gnt_any
);

    logic [IDW-1:0] cand_s;
    logic [IDW-1:0] hit_idx_s;
    logic           hit_s;

    // Walk offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        cand_s    = last;
        hit_idx_s = last;
        hit_s     = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            cand_s    = IDW'((int'(last) + k) % NREQ);
            hit_idx_s = req[cand_s] ? cand_s : hit_idx_s;
            hit_s     = hit_s | req[cand_s];
        end
    end

    // One-hot form of the winning index, zero when nobody requests.
    always_comb begin
        gnt            = '0;
        gnt[hit_idx_s] = hit_s;
    end

    assign gnt_idx = hit_idx_s;
    assign gnt_any = hit_s;

endmodule

// File: rtl/gf_add_arbiter.sv
// Round-robin arbiter time-sharing one gf_rca_adder among NREQ requesters.
// Optional macro GF_ARB_OPREG_EN inserts an operand register stage (latency 2).
module gf_add_arbiter
    import gf_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int W    = GF_W,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    input  logic [NREQ-1:0]   req_gf,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [W-1:0]      rsp_data,
    output logic [IDW-1:0]    rsp_id
);

    logic [NREQ-1:0] gnt_s;
    logic [IDW-1:0]  gnt_idx_s;
    logic            gnt_any_s;
    logic            slot_free_s;
    logic            grant_s;
    gf_arb_req_t     sel_s;
    gf_arb_req_t     add_in_s;
    logic [W-1:0]    sum_s;

    gf_arb_state_t   state_q, state_d;
    logic [W-1:0]    data_q, data_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [IDW-1:0]  last_q, last_d;

    rr_grant #(.NREQ(NREQ), .IDW(IDW)) u_rr_grant (
        .req     (req_valid),
        .last    (last_q),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s),
        .gnt_any (gnt_any_s)
    );

    // Operand mux: pick the granted requester's a, b and mode.
    always_comb begin
        sel_s.a  = req_a[gnt_idx_s*W +: W];
        sel_s.b  = req_b[gnt_idx_s*W +: W];
        sel_s.gf = req_gf[gnt_idx_s];
    end

`ifdef GF_ARB_OPREG_EN
    gf_arb_req_t     op_q, op_d;
    logic            op_valid_q, op_valid_d;
    logic [IDW-1:0]  op_id_q, op_id_d;
    logic            stall_s;

    assign stall_s     = (state_q == ST_FULL) && !rsp_ready;
    assign slot_free_s = !op_valid_q || !stall_s;
    assign add_in_s    = op_q;
`else
    assign slot_free_s = (state_q == ST_EMPTY) || rsp_ready;
    assign add_in_s    = sel_s;
`endif

    // Grants are suppressed while reset is held so no requester sees ready.
    assign grant_s   = rst_n & slot_free_s & gnt_any_s;
    assign req_ready = {NREQ{grant_s}} & gnt_s;

    gf_rca_adder #(.W(W)) u_adder (
        .a   (add_in_s.a),
        .b   (add_in_s.b),
        .gf  (add_in_s.gf),
        .sum (sum_s)
    );

    // Next-state for the output slot, the round-robin pointer and operand stage.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        id_d    = id_q;
        last_d  = grant_s ? gnt_idx_s : last_q;
`ifdef GF_ARB_OPREG_EN
        op_valid_d = op_valid_q;
        op_d       = op_q;
        op_id_d    = op_id_q;
        if (grant_s) begin
            op_valid_d = 1'b1;
            op_d       = sel_s;
            op_id_d    = gnt_idx_s;
        end else if (!stall_s) begin
            op_valid_d = 1'b0;
        end else begin
            op_valid_d = op_valid_q;
        end
        if (stall_s) begin
            state_d = state_q;
        end else if (op_valid_q) begin
            state_d = ST_FULL;
            data_d  = sum_s;
            id_d    = op_id_q;
        end else begin
            state_d = ST_EMPTY;
        end
`else
        if (grant_s) begin
            state_d = ST_FULL;
            data_d  = sum_s;
            id_d    = gnt_idx_s;
        end else if (rsp_ready) begin
            state_d = ST_EMPTY;
        end else begin
            state_d = state_q;
        end
`endif
    end

    // State registers; last resets to NREQ-1 so requester 0 leads after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_EMPTY;
            data_q     <= '0;
            id_q       <= '0;
            last_q     <= IDW'(NREQ - 1);
`ifdef GF_ARB_OPREG_EN
            op_valid_q <= 1'b0;
            op_q       <= '0;
            op_id_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            id_q       <= id_d;
            last_q     <= last_d;
`ifdef GF_ARB_OPREG_EN
            op_valid_q <= op_valid_d;
            op_q       <= op_d;
            op_id_q    <= op_id_d;
`endif
        end
    end

    assign rsp_valid = (state_q == ST_FULL);
    assign rsp_data  = data_q;
    assign rsp_id    = id_q;

endmodule

// File: tb/tb_gf_add_arbiter.sv
// Scoreboard bench for gf_add_arbiter (default single-stage build): a
// behavioural arbitration model predicts grants and results, a monitor checks them.
module tb_gf_add_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_gf;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_data;
    logic [IDW-1:0]    rsp_id;

    gf_add_arbiter #(.NREQ(NREQ)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_gf    (req_gf),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]   data;
        logic [IDW-1:0] id;
    } rsp_t;

    rsp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [W-1:0] va[NREQ];
    logic [W-1:0] vb[NREQ];
    logic        vg[NREQ];
    logic        vv[NREQ];
    logic        rr;
    int          m_last;
    bit          m_full;
    int          acc;
    int          wait_cnt[NREQ];
    logic [W-1:0] held;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] ref_op(logic [W-1:0] a, logic [W-1:0] b, logic g);
        logic [W-1:0] r;
        r = g ? (a ^ b) : (a + b);
        return r;
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = va[i];
            req_b[i*W +: W] = vb[i];
            req_gf[i]       = vg[i];
            req_valid[i]    = vv[i];
        end
        rsp_ready = rr;
    endtask

    task automatic arm(int i);
        va[i] = $urandom;
        vb[i] = $urandom;
        vg[i] = 1'($urandom_range(0, 1));
        vv[i] = 1'b1;
    endtask

    // One cycle: drive at posedge+1, predict and check at negedge, return at posedge+1.
    task automatic step();
        logic [NREQ-1:0] exp_rdy;
        drive();
        @(negedge clk);
        acc = -1;
        if (!m_full || rr) begin
            for (int k = 1; k <= NREQ; k++) begin
                if (vv[(m_last + k) % NREQ] && acc < 0) acc = (m_last + k) % NREQ;
            end
        end
        exp_rdy = '0;
        if (acc >= 0) exp_rdy[acc] = 1'b1;
        chk("rsp_valid", 64'(rsp_valid), 64'(m_full));
        chk("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (acc >= 0) begin
            for (int i = 0; i < NREQ; i++) if (vv[i] && i != acc) wait_cnt[i]++;
            chk("starve_bound", 64'(wait_cnt[acc] < NREQ), 64'd1);
            wait_cnt[acc] = 0;
            exp_q.push_back('{data: ref_op(va[acc], vb[acc], vg[acc]), id: IDW'(acc)});
            m_last = acc;
            m_full = 1'b1;
        end else if (rr) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive();
        #1;
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        exp_q.delete();
        m_full = 1'b0;
        m_last = NREQ - 1;
        for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: every presented result must match the oldest expected one.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got id %0d data %0h, expected none", rsp_id, rsp_data);
            end else begin
                chk("rsp_data", 64'(rsp_data), 64'(exp_q[0].data));
                chk("rsp_id", 64'(rsp_id), 64'(exp_q[0].id));
                if (rsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            va[i] = '0; vb[i] = '0; vg[i] = 1'b0; vv[i] = 1'b0; wait_cnt[i] = 0;
        end
        rr = 1'b1;
        req_valid = '0; req_a = '0; req_b = '0; req_gf = '0; rsp_ready = 1'b1;
        #2;
        do_reset();

        // Single integer request from rq0.
        va[0] = 32'h0000_0005; vb[0] = 32'h0000_0003; vg[0] = 1'b0; vv[0] = 1'b1;
        step();
        chk("t1_accept", 64'(acc), 64'd0);
        chk("t1_data", 64'(rsp_data), 64'h0000_0008);
        chk("t1_id", 64'(rsp_id), 64'd0);
        vv[0] = 1'b0;

        // GF mode from rq2.
        va[2] = 32'hFFFF_0000; vb[2] = 32'h0F0F_0F0F; vg[2] = 1'b1; vv[2] = 1'b1;
        step();
        chk("gf_data", 64'(rsp_data), 64'hF0F0_0F0F);
        chk("gf_id", 64'(rsp_id), 64'd2);
        vv[2] = 1'b0;

        // Integer wrap from rq3.
        va[3] = 32'hFFFF_FFFF; vb[3] = 32'h0000_0001; vg[3] = 1'b0; vv[3] = 1'b1;
        step();
        chk("wrap_data", 64'(rsp_data), 64'h0000_0000);
        chk("wrap_id", 64'(rsp_id), 64'd3);
        vv[3] = 1'b0;

        // All requesters continuously valid: strict 0,1,2,3 rotation.
        for (int i = 0; i < NREQ; i++) arm(i);
        for (int n = 0; n < 12; n++) begin
            step();
            chk("rr_order", 64'(acc), 64'(n % NREQ));
            if (acc >= 0) arm(acc);
        end
        for (int i = 0; i < NREQ; i++) vv[i] = 1'b0;
        step();

        // Backpressure with rq1 waiting.
        arm(0);
        step();
        vv[0] = 1'b0;
        held = ref_op(va[0], vb[0], vg[0]);
        arm(1);
        rr = 1'b0;
        for (int n = 0; n < 3; n++) begin
            step();
            chk("bp_no_grant", 64'(acc < 0), 64'd1);
            chk("bp_hold_data", 64'(rsp_data), 64'(held));
            chk("bp_hold_id", 64'(rsp_id), 64'd0);
        end
        rr = 1'b1;
        step();
        chk("bp_release", 64'(acc), 64'd1);
        vv[1] = 1'b0;
        step();

        // Reset while a result is held.
        arm(2);
        rr = 1'b0;
        step();
        vv[2] = 1'b0;
        arm(0);
        arm(3);
        step();
        do_reset();
        rr = 1'b1;
        step();
        chk("post_rst_first", 64'(acc), 64'd0);
        vv[0] = 1'b0;
        step();
        chk("post_rst_second", 64'(acc), 64'd3);
        vv[3] = 1'b0;

        // Random traffic with random backpressure.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!vv[i] && $urandom_range(0, 99) < 40) arm(i);
            end
            rr = ($urandom_range(0, 3) != 0);
            step();
            if (acc >= 0) vv[acc] = 1'b0;
        end

        for (int i = 0; i < NREQ; i++) vv[i] = 1'b0;
        rr = 1'b1;
        repeat (3) step();
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
